// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS word registers with byte strobes, driven out on reg_out.
// Define AXIL_REG_SLVERR_EN to answer unmapped addresses with SLVERR instead of OKAY.
module axil_reg_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REGS   = 4,
  parameter int BASE_ADDR  = 0
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                           s_axi_awvalid,
  output logic                           s_axi_awready,
  input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
  input  logic                           s_axi_wvalid,
  output logic                           s_axi_wready,
  output logic [RESP_WIDTH-1:0]          s_axi_bresp,
  output logic                           s_axi_bvalid,
  input  logic                           s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                           s_axi_arvalid,
  output logic                           s_axi_arready,
  output logic [DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [RESP_WIDTH-1:0]          s_axi_rresp,
  output logic                           s_axi_rvalid,
  input  logic                           s_axi_rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);
  // state     | meaning
  // W_IDLE    | waiting for AW and/or W
  // W_HAVE_AW | address captured, waiting for W
  // W_HAVE_W  | data captured, waiting for AW
  // W_RESP    | B response pending
  // R_IDLE    | waiting for AR
  // R_RESP    | R response pending
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-2:0] NREGS = (ADDR_WIDTH-1)'(NUM_REGS);
  localparam logic [RESP_WIDTH-1:0] RESP_OKAY = '0;
`ifdef AXIL_REG_SLVERR_EN
  localparam logic [RESP_WIDTH-1:0] RESP_MISS = RESP_WIDTH'(2);
`else
  localparam logic [RESP_WIDTH-1:0] RESP_MISS = '0;
`endif

  w_state_e                w_state_q;
  r_state_e                r_state_q;
  logic                    awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [RESP_WIDTH-1:0]   bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

  logic                    aw_hs, w_hs, ar_hs, wr_fire, wr_hit, rd_hit;
  logic [ADDR_WIDTH-1:0]   wr_addr, wr_off, rd_off;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [STRB_W-1:0]       wr_strb;
  logic [IDX_W-1:0]        wr_idx, rd_idx;

  assign aw_hs = s_axi_awvalid & awready_q;
  assign w_hs  = s_axi_wvalid & wready_q;
  assign ar_hs = s_axi_arvalid & arready_q;

  // Commit uses the captured half of the transaction and the live half of the other.
  always_comb begin
    wr_addr = (w_state_q == W_HAVE_AW) ? aw_addr_q : s_axi_awaddr;
    wr_data = (w_state_q == W_HAVE_W) ? w_data_q : s_axi_wdata;
    wr_strb = (w_state_q == W_HAVE_W) ? w_strb_q : s_axi_wstrb;
    wr_fire = ((w_state_q == W_IDLE) && aw_hs && w_hs) ||
              ((w_state_q == W_HAVE_AW) && w_hs) ||
              ((w_state_q == W_HAVE_W) && aw_hs);
    wr_off  = wr_addr - BASE;
    wr_hit  = (wr_off[1:0] == 2'b00) && ({1'b0, wr_off[ADDR_WIDTH-1:2]} < NREGS);
    wr_idx  = wr_off[IDX_W+1:2];
    rd_off  = s_axi_araddr - BASE;
    rd_hit  = (rd_off[1:0] == 2'b00) && ({1'b0, rd_off[ADDR_WIDTH-1:2]} < NREGS);
    rd_idx  = rd_off[IDX_W+1:2];
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_fire) begin
      if (wr_hit) begin
        for (int b = 0; b < STRB_W; b++)
          if (wr_strb[b]) regs_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
      bresp_q   <= wr_hit ? RESP_OKAY : RESP_MISS;
      bvalid_q  <= 1'b1;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      w_state_q <= W_RESP;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr_q <= s_axi_awaddr;
            awready_q <= 1'b0;
            w_state_q <= W_HAVE_AW;
          end else if (w_hs) begin
            w_data_q  <= s_axi_wdata;
            w_strb_q  <= s_axi_wstrb;
            wready_q  <= 1'b0;
            w_state_q <= W_HAVE_W;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Non-blocking read of regs_q gives the pre-write value on a same-edge collision.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rdata_q   <= rd_hit ? regs_q[rd_idx] : '0;
            rresp_q   <= rd_hit ? RESP_OKAY : RESP_MISS;
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_RESP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axi_rready) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed testbench for axil_reg_slave (default parameters).
module tb_axil_reg_slave;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   awaddr, araddr;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [2:0]   bresp, rresp;
  logic [127:0] reg_out;
  int           vectors = 0;
  int           miscompares = 0;

`ifdef AXIL_REG_SLVERR_EN
  localparam logic [2:0] MISS = 3'd2;
`else
  localparam logic [2:0] MISS = 3'd0;
`endif

  axil_reg_slave dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .reg_out(reg_out)
  );

  always #5 clk = ~clk;

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [2:0] resp, output bit ok);
    bit aw_done, w_done, a_hs, d_hs;
    ok = 1'b0; resp = '0; aw_done = 1'b0; w_done = 1'b0;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      @(posedge clk); @(negedge clk);
      if (a_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (d_hs) begin wvalid = 1'b0; w_done = 1'b1; end
    end
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bvalid) begin resp = bresp; ok = 1'b1; end
      @(posedge clk); @(negedge clk);
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, output logic [31:0] data, output logic [2:0] resp,
                         output bit ok);
    bit done, a_hs;
    ok = 1'b0; data = '0; resp = '0; done = 1'b0;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      a_hs = arvalid && arready;
      @(posedge clk); @(negedge clk);
      if (a_hs) begin arvalid = 1'b0; done = 1'b1; end
    end
    for (int i = 0; i < 20 && !ok && done; i++) begin
      if (rvalid) begin data = rdata; resp = rresp; ok = 1'b1; end
      @(posedge clk); @(negedge clk);
    end
    arvalid = 1'b0; rready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({awready, wready, arready} !== 3'b000) begin
      miscompares++; $display("FAIL reset_readies: got %b exp 000", {awready, wready, arready});
    end
    vectors++;
    if ({bvalid, rvalid, bresp, rresp} !== 8'h00) begin
      miscompares++; $display("FAIL reset_valid_resp: got %h exp 00", {bvalid, rvalid, bresp, rresp});
    end
    vectors++;
    if (rdata !== 32'h0 || reg_out !== 128'h0) begin
      miscompares++; $display("FAIL reset_data: rdata %h reg_out %h exp 0", rdata, reg_out);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({awready, wready, arready} !== 3'b000) begin
      miscompares++; $display("FAIL release_readies_early: got %b exp 000", {awready, wready, arready});
    end
    @(negedge clk);
    vectors++;
    if ({awready, wready, arready} !== 3'b111) begin
      miscompares++; $display("FAIL release_readies: got %b exp 111", {awready, wready, arready});
    end
  endtask

  task automatic test_write_same_cycle;
    @(negedge clk);
    awaddr = 8'h00; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1; bready = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0;
    vectors++;
    if ({bvalid, bresp, awready, wready} !== 6'b1_000_00) begin
      miscompares++; $display("FAIL wr_same_b: got bvalid %b bresp %0d aw/w rdy %b%b exp 1 0 00",
                              bvalid, bresp, awready, wready);
    end
    vectors++;
    if (reg_out[31:0] !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL wr_same_reg0: got %h exp deadbeef", reg_out[31:0]);
    end
    @(posedge clk); @(negedge clk);
    bready = 0;
    vectors++;
    if ({bvalid, awready, wready} !== 3'b011) begin
      miscompares++; $display("FAIL wr_same_bdone: got %b exp 011", {bvalid, awready, wready});
    end
  endtask

  task automatic test_aw_before_w;
    @(negedge clk);
    awaddr = 8'h08; awvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({awready, wready, bvalid} !== 3'b010) begin
        miscompares++; $display("FAIL aw_first_wait%0d: aw/w/b %b exp 010", i, {awready, wready, bvalid});
      end
      if (i < 2) begin @(posedge clk); @(negedge clk); end
    end
    wdata = 32'h12345678; wstrb = 4'h5; wvalid = 1; bready = 0;
    @(posedge clk); @(negedge clk);
    wvalid = 0;
    vectors++;
    if ({bvalid, bresp} !== 4'b1_000 || reg_out[95:64] !== 32'h00340078) begin
      miscompares++; $display("FAIL aw_first_commit: bvalid %b bresp %0d reg2 %h exp 1 0 00340078",
                              bvalid, bresp, reg_out[95:64]);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bvalid !== 1'b1 || bresp !== 3'd0) begin
      miscompares++; $display("FAIL aw_first_bhold: bvalid %b bresp %0d exp 1 0", bvalid, bresp);
    end
    bready = 1;
    @(posedge clk); @(negedge clk);
    bready = 0;
    @(negedge clk);
    vectors++;
    if (bvalid !== 1'b0) begin
      miscompares++; $display("FAIL aw_first_single_b: bvalid %b exp 0", bvalid);
    end
  endtask

  task automatic test_read_backpressure;
    logic [2:0] r; bit ok;
    do_write(8'h0C, 32'hCAFEF00D, 4'hF, r, ok);
    vectors++;
    if (!ok || r !== 3'd0) begin
      miscompares++; $display("FAIL rd_bp_write: ok %0d bresp %0d exp 1 0", ok, r);
    end
    @(negedge clk);
    araddr = 8'h0C; arvalid = 1; rready = 0;
    @(posedge clk); @(negedge clk);
    arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({rvalid, arready} !== 2'b10 || rdata !== 32'hCAFEF00D || rresp !== 3'd0) begin
        miscompares++; $display("FAIL rd_bp_hold%0d: rvalid %b arready %b rdata %h rresp %0d exp 1 0 cafef00d 0",
                                i, rvalid, arready, rdata, rresp);
      end
      if (i < 3) begin @(posedge clk); @(negedge clk); end
    end
    rready = 1;
    @(posedge clk); @(negedge clk);
    rready = 0;
    vectors++;
    if ({rvalid, arready} !== 2'b01) begin
      miscompares++; $display("FAIL rd_bp_done: rvalid/arready %b exp 01", {rvalid, arready});
    end
  endtask

  task automatic test_miss;
    logic [2:0] r; logic [31:0] d; bit ok;
    do_write(8'h10, 32'h55555555, 4'hF, r, ok);
    vectors++;
    if (!ok || r !== MISS) begin
      miscompares++; $display("FAIL miss_bresp: ok %0d bresp %0d exp 1 %0d", ok, r, MISS);
    end
    vectors++;
    if (reg_out !== {32'hCAFEF00D, 32'h00340078, 32'h00000000, 32'hDEADBEEF}) begin
      miscompares++; $display("FAIL miss_regs: got %h", reg_out);
    end
    do_read(8'h10, d, r, ok);
    vectors++;
    if (!ok || d !== 32'h0 || r !== MISS) begin
      miscompares++; $display("FAIL miss_read: ok %0d rdata %h rresp %0d exp 1 0 %0d", ok, d, r, MISS);
    end
    do_read(8'h0E, d, r, ok);
    vectors++;
    if (!ok || d !== 32'h0 || r !== MISS) begin
      miscompares++; $display("FAIL misaligned_read: ok %0d rdata %h rresp %0d exp 1 0 %0d", ok, d, r, MISS);
    end
  endtask

  task automatic test_collision;
    logic [2:0] r; logic [31:0] d; bit ok;
    do_write(8'h04, 32'hAAAAAAAA, 4'hF, r, ok);
    @(negedge clk);
    awaddr = 8'h04; awvalid = 1; wdata = 32'h11111111; wstrb = 4'hF; wvalid = 1; bready = 1;
    araddr = 8'h04; arvalid = 1; rready = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    vectors++;
    if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'hAAAAAAAA) begin
      miscompares++; $display("FAIL collide_read: rvalid %b bvalid %b rdata %h exp 1 1 aaaaaaaa",
                              rvalid, bvalid, rdata);
    end
    vectors++;
    if (reg_out[63:32] !== 32'h11111111) begin
      miscompares++; $display("FAIL collide_reg1: got %h exp 11111111", reg_out[63:32]);
    end
    @(posedge clk); @(negedge clk);
    bready = 0; rready = 0;
    do_read(8'h04, d, r, ok);
    vectors++;
    if (!ok || d !== 32'h11111111 || r !== 3'd0) begin
      miscompares++; $display("FAIL collide_reread: ok %0d rdata %h rresp %0d exp 1 11111111 0", ok, d, r);
    end
    do_write(8'h04, 32'hFFFFFFFF, 4'h0, r, ok);
    vectors++;
    if (!ok || r !== 3'd0 || reg_out[63:32] !== 32'h11111111) begin
      miscompares++; $display("FAIL zero_strb: ok %0d bresp %0d reg1 %h exp 1 0 11111111", ok, r, reg_out[63:32]);
    end
    do_write(8'h04, 32'h2233CCDD, 4'hA, r, ok);
    vectors++;
    if (!ok || reg_out[63:32] !== 32'h2211CC11) begin
      miscompares++; $display("FAIL strb_a: ok %0d reg1 %h exp 2211cc11", ok, reg_out[63:32]);
    end
  endtask

  task automatic test_reset_midflight;
    @(negedge clk);
    awaddr = 8'h00; awvalid = 1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1; bready = 0;
    araddr = 8'h00; arvalid = 1; rready = 0;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    vectors++;
    if ({bvalid, rvalid} !== 2'b11) begin
      miscompares++; $display("FAIL midflight_pending: b/r valid %b exp 11", {bvalid, rvalid});
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b0) begin
      miscompares++; $display("FAIL midflight_async: b/r valid, readies %b exp 00000",
                              {bvalid, rvalid, awready, wready, arready});
    end
    vectors++;
    if (reg_out !== 128'h0) begin
      miscompares++; $display("FAIL midflight_regs: got %h exp 0", reg_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
      miscompares++; $display("FAIL midflight_release: readies,b,r %b exp 11100",
                              {awready, wready, arready, bvalid, rvalid});
    end
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_aw_before_w();
    test_read_backpressure();
    test_miss();
    test_collision();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, exp completion");
    $fatal(1);
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
- AXI4-Lite responder (memory-mapped register bank) that sits on the far side of the bus's m1/m2 master ports.
- Accepts single-beat writes and reads and holds NUM_REGS word-wide registers.
- Drives the register contents out to fabric logic.
- Write and read channels run independently and concurrently.

Parameters:
- DATA_WIDTH, 32, register/data width; multiple of 8.
- ADDR_WIDTH, 8, AXI address width.
- RESP_WIDTH, 3, bresp/rresp width. OKAY=0, SLVERR=2; unused upper bits are 0.
- NUM_REGS, 4, number of registers (power of 2, 1..64).
- BASE_ADDR, 0, byte address of register 0; word aligned.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  async active-low reset
- s_axi_awaddr  in  ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_WIDTH  write data
- s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  RESP_WIDTH  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_WIDTH  read data
- s_axi_rresp  out  RESP_WIDTH  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i = bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Interface: one clock, s_axi_aclk. Reset s_axi_aresetn is asynchronous, active-low.
- Reset values: all readies 0, bvalid/rvalid 0, bresp/rresp 0, rdata 0, all registers 0.
- Readies go to 1 on the first rising edge after reset deasserts.
- Address decode: offset = addr - BASE_ADDR.
  - Hit when offset[1:0]==0 and offset>>2 < NUM_REGS; index = offset>>2.
  - Any other address is a miss.
- Write FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP:
  - W_IDLE: awready=wready=1.
  - AW handshake alone: capture awaddr, awready<=0, go to W_HAVE_AW.
  - W handshake alone: capture wdata/wstrb, wready<=0, go to W_HAVE_W.
  - Both handshakes in the same cycle: go directly to commit.
  - W_HAVE_AW waits for W; W_HAVE_W waits for AW.
  - Commit happens at the edge of the final handshake:
    - Hit: bytes with wstrb=1 updated, others kept, bresp=OKAY.
    - Miss: no register changes, bresp per optional feature.
    - bvalid<=1, both readies 0, enter W_RESP.
  - W_RESP: bvalid and bresp held stable until bready. On the B handshake edge: bvalid<=0, awready<=1, wready<=1, back to W_IDLE.
  - wstrb=0 on a hit: register unchanged, bresp=OKAY.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: arready=1.
  - On AR handshake: rdata<=register[index] (hit) or 0 (miss); rresp per decode; rvalid<=1; arready<=0; go to R_RESP.
  - R_RESP: rdata/rresp/rvalid held until rready. On the R handshake: rvalid<=0, arready<=1.
  - Minimum 2 cycles per read.
- Latency:
  - Write: bvalid high on the cycle after the final AW/W handshake.
  - Read: rvalid high on the cycle after the AR handshake.
- Read/write collision: a same-edge read and write commit to the same register return the pre-write value.
- reg_out is the registers directly; it reflects a write on the cycle after commit.
- Reset mid-transaction: all FSMs go to idle and valids drop immediately (asynchronous). In-flight transactions are discarded.

Optional Feature:
- Macro AXIL_REG_SLVERR_EN.
- Defined: a miss returns SLVERR (2) on bresp/rresp.
- Undefined: a miss returns OKAY (0); the write is silently dropped and the read returns 0.
- Register behaviour on hits is identical either way.

Test Plan:
- Write 0x0 data 0xDEADBEEF wstrb 0xF, AW and W same cycle, bready=1 -> bvalid the next cycle with bresp=0; reg_out[31:0]=0xDEADBEEF.
- AW 0x8 three cycles before W (data 0x12345678, wstrb 0x5) onto reg2=0 -> wready stays 1 while awready=0; reg2=0x00340078 after commit; single B response.
- Read 0xC after writing 0xCAFEF00D, rready held low 4 cycles -> rvalid=1 with rdata=0xCAFEF00D stable all 4 cycles; arready=0 until the R handshake.
- Write and read 0x10 (miss) -> regs unchanged, rdata=0; resp=2 with AXIL_REG_SLVERR_EN, 0 without.
- Same-cycle write 0x4 (0x11111111 over 0xAAAAAAAA) and read 0x4 -> rdata=0xAAAAAAAA; a subsequent read returns 0x11111111.
- Assert reset while bvalid=1 and rvalid=1 -> both drop asynchronously; all registers=0; readies=1 one edge after release.
